// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_scan_ctrl
//  Purpose  : Frame-based dual-pattern serial detector with saturating
//             per-pattern match counters and a valid/ready bit interface.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl #(
    parameter int PLEN  = 5,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [PLEN-1:0]  pat0,
    input  logic [PLEN-1:0]  pat1,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             busy,
    output logic             match0,
    output logic             match1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             done
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_SCAN    = 2'd1;
    localparam logic [1:0]       c_DONE    = 2'd2;
    localparam logic [LEN_W:0]   c_PLEN    = (LEN_W+1)'(PLEN);
    localparam logic [LEN_W:0]   c_LEN_ONE = (LEN_W+1)'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [PLEN-1:0]  r_pat0;
    logic [PLEN-1:0]  r_pat1;
    logic [PLEN-1:0]  r_hist;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_bitcnt;
    logic             r_match0;
    logic             r_match1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic [PLEN-1:0]  w_window;
    logic [LEN_W:0]   w_cnt_next;
    logic             w_accept;
    logic             w_start;
    logic             w_full;
    logic             w_last;
    logic             w_hit0;
    logic             w_hit1;

    assign w_accept   = bit_valid & bit_ready;
    assign w_start    = (r_state == c_IDLE) & start;
    assign w_window   = {r_hist[PLEN-2:0], bit_in};
    assign w_cnt_next = {1'b0, r_bitcnt} + c_LEN_ONE;
    // The window is only meaningful once PLEN bits of this frame have arrived.
    assign w_full     = (w_cnt_next >= c_PLEN);
    assign w_last     = (w_cnt_next == {1'b0, r_len});
    assign w_hit0     = w_accept & w_full & (w_window == r_pat0);
    assign w_hit1     = w_accept & w_full & (w_window == r_pat1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next = (frame_len == '0) ? c_DONE : c_SCAN;
                end
            end
            c_SCAN: begin
                if (w_accept && w_last) begin
                    w_next = c_DONE;
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        bit_ready = (r_state == c_SCAN);
        busy      = (r_state == c_SCAN);
        done      = (r_state == c_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat0   <= '0;
            r_pat1   <= '0;
            r_len    <= '0;
            r_hist   <= '0;
            r_bitcnt <= '0;
            r_match0 <= 1'b0;
            r_match1 <= 1'b0;
            r_cnt0   <= '0;
            r_cnt1   <= '0;
        end else begin
            r_match0 <= w_hit0;
            r_match1 <= w_hit1;
            if (w_start) begin
                r_pat0   <= pat0;
                r_pat1   <= pat1;
                r_len    <= frame_len;
                r_hist   <= '0;
                r_bitcnt <= '0;
                r_cnt0   <= '0;
                r_cnt1   <= '0;
            end else if (w_accept) begin
                r_hist   <= w_window;
                r_bitcnt <= w_cnt_next[LEN_W-1:0];
                if (w_hit0 && (r_cnt0 != c_CNT_MAX)) begin
                    r_cnt0 <= r_cnt0 + c_CNT_ONE;
                end
                if (w_hit1 && (r_cnt1 != c_CNT_MAX)) begin
                    r_cnt1 <= r_cnt1 + c_CNT_ONE;
                end
            end
        end
    end

    assign match0 = r_match0;
    assign match1 = r_match1;
    assign cnt0   = r_cnt0;
    assign cnt1   = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_scan_ctrl
//  Purpose  : Directed plus randomized bench for seq_scan_ctrl, two instances
//             (5-bit patterns / 8-bit counters and 2-bit patterns / 2-bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic [7:0] frame_len = '0;
    logic [4:0] pat0 = '0;
    logic [4:0] pat1 = '0;

    logic       a_ready, a_busy, a_m0, a_m1, a_done;
    logic [7:0] a_c0, a_c1;
    logic       b_ready, b_busy, b_m0, b_m1, b_done;
    logic [1:0] b_c0, b_c1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.PLEN(5), .LEN_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .pat0(pat0), .pat1(pat1), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(a_ready), .busy(a_busy), .match0(a_m0), .match1(a_m1),
        .cnt0(a_c0), .cnt1(a_c1), .done(a_done)
    );

    seq_scan_ctrl #(.PLEN(2), .LEN_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .pat0(pat0[1:0]), .pat1(pat1[1:0]), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(b_ready), .busy(b_busy), .match0(b_m0), .match1(b_m1),
        .cnt0(b_c0), .cnt1(b_c1), .done(b_done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 scanning, 2 done; keeps the whole frame.
    int         m_mode = 0;
    int         m_len = 0;
    int         m_nacc = 0;
    logic [4:0] m_p0 = '0;
    logic [4:0] m_p1 = '0;
    bit         m_bits [256];
    int         e_cnt [2][2];
    bit         e_m [2][2];

    function automatic bit model_hit(input int pl, input logic [4:0] p);
        if (m_nacc < pl) return 1'b0;
        for (int j = 0; j < pl; j++)
            if (m_bits[m_nacc-pl+j] != p[pl-1-j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_len = 0; m_nacc = 0; m_p0 = '0; m_p1 = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 2; i++) begin
                e_cnt[k][i] = 0;
                e_m[k][i]   = 1'b0;
            end
    endtask

    task automatic model_step();
        int pl, cmax;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 2; i++) e_m[k][i] = 1'b0;
        case (m_mode)
            0: if (start) begin
                m_len = int'(frame_len); m_p0 = pat0; m_p1 = pat1; m_nacc = 0;
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 2; i++) e_cnt[k][i] = 0;
                m_mode = (frame_len == 0) ? 2 : 1;
            end
            1: if (bit_valid) begin
                m_bits[m_nacc] = bit_in;
                m_nacc++;
                for (int k = 0; k < 2; k++) begin
                    pl   = (k == 0) ? 5 : 2;
                    cmax = (k == 0) ? 255 : 3;
                    if (model_hit(pl, m_p0)) begin
                        e_m[k][0] = 1'b1;
                        if (e_cnt[k][0] < cmax) e_cnt[k][0]++;
                    end
                    if (model_hit(pl, m_p1)) begin
                        e_m[k][1] = 1'b1;
                        if (e_cnt[k][1] < cmax) e_cnt[k][1]++;
                    end
                end
                if (m_nacc == m_len) m_mode = 2;
            end
            default: m_mode = 0;
        endcase
    endtask

    // Compare on the falling edge, then advance the model to the next rising edge.
    initial forever begin
        @(negedge clk);
        if (rst) model_reset();
        chk("a_ready", a_ready, m_mode == 1);
        chk("a_busy",  a_busy,  m_mode == 1);
        chk("a_done",  a_done,  m_mode == 2);
        chk("a_match0", a_m0, e_m[0][0]);
        chk("a_match1", a_m1, e_m[0][1]);
        chk("a_cnt0", a_c0, e_cnt[0][0]);
        chk("a_cnt1", a_c1, e_cnt[0][1]);
        chk("b_ready", b_ready, m_mode == 1);
        chk("b_done",  b_done,  m_mode == 2);
        chk("b_match0", b_m0, e_m[1][0]);
        chk("b_match1", b_m1, e_m[1][1]);
        chk("b_cnt0", b_c0, e_cnt[1][0]);
        chk("b_cnt1", b_c1, e_cnt[1][1]);
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame; bit i (first received = 0) is seq[len-1-i].
    task automatic run_frame(input int len, input logic [4:0] p0, input logic [4:0] p1,
                             input logic [255:0] seq, input int vmode,
                             input int rst_after, input bit poke, output bit aborted);
        int  idx = 0;
        int  cyc = 0;
        bit  acc;
        aborted   = 1'b0;
        start     = 1'b1;
        frame_len = 8'(len);
        pat0      = p0;
        pat1      = p1;
        bit_valid = 1'($urandom_range(0, 1));
        tick();
        start     = 1'b0;
        frame_len = 8'($urandom);
        pat0      = 5'($urandom);
        pat1      = 5'($urandom);
        while (idx < len && cyc < 1000) begin
            if (rst_after >= 0 && idx == rst_after) begin
                rst = 1'b1; bit_valid = 1'b0;
                tick(); tick();
                rst = 1'b0;
                chk("no_done_after_rst", a_done, 0);
                chk("cnt_cleared_by_rst", a_c0, 0);
                aborted = 1'b1;
                return;
            end
            bit_in    = seq[len-1-idx];
            bit_valid = (vmode == 0) ? 1'b1 :
                        (vmode == 1) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 3) != 0);
            start     = poke && (cyc == 2);
            acc       = bit_valid && a_ready;
            tick();
            cyc++;
            if (acc) idx++;
        end
        if (cyc >= 1000) chk("frame_timeout", cyc, 0);
        start     = 1'b0;
        bit_valid = 1'b0;
        chk("done_after_last", a_done, 1);
        chk("busy_at_done", a_busy, 0);
    endtask

    initial begin
        bit ab;
        logic [255:0] seq;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_cnt0", a_c0, 0);
        chk("reset_done", a_done, 0);
        tick();

        run_frame(8, 5'b11011, 5'b11101, 256'b11011011, 0, -1, 0, ab);
        chk("t1_cnt0", a_c0, 2); chk("t1_cnt1", a_c1, 0);
        tick();
        run_frame(9, 5'b11011, 5'b11101, 256'b111011011, 0, -1, 0, ab);
        chk("t2_final_match0", a_m0, 1);
        chk("t2_cnt0", a_c0, 2); chk("t2_cnt1", a_c1, 1);
        tick();
        run_frame(0, 5'b11011, 5'b11101, 256'b0, 0, -1, 0, ab);
        chk("t3_cnt0", a_c0, 0); chk("t3_cnt1", a_c1, 0);
        tick();
        run_frame(7, 5'b11111, 5'b11111, 256'b1111111, 1, -1, 0, ab);
        chk("t4_cnt0", a_c0, 3); chk("t4_cnt1", a_c1, 3);
        tick();
        run_frame(8, 5'b11011, 5'b11101, 256'b11011011, 0, 3, 0, ab);
        tick();
        run_frame(5, 5'b11011, 5'b11101, 256'b11011, 0, -1, 0, ab);
        chk("t5_cnt0", a_c0, 1);
        tick();
        run_frame(8, 5'b00011, 5'b00000, 256'hFF, 0, -1, 1, ab);
        chk("t6_b_cnt0_sat", b_c0, 3); chk("t6_a_cnt0", a_c0, 0);
        tick();

        for (int f = 0; f < 40; f++) begin
            int len;
            logic [4:0] p0, p1;
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
            p0  = 5'($urandom);
            p1  = ($urandom_range(0, 3) == 0) ? p0 : 5'($urandom);
            for (int i = 0; i < 256; i++)
                seq[i] = (f % 2 == 0) ? p0[i % 5] ^ ($urandom_range(0, 15) == 0)
                                      : 1'($urandom_range(0, 1));
            run_frame(len, p0, p1, seq, int'($urandom_range(0, 2)),
                      (len > 2 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, len-1)) : -1,
                      (len > 4 && $urandom_range(0, 2) == 0), ab);
            repeat ($urandom_range(1, 3)) begin
                bit_valid = 1'($urandom_range(0, 1));
                bit_in    = 1'($urandom_range(0, 1));
                tick();
            end
            bit_valid = 1'b0;
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
